// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encodings and default data width for the uart transmit path.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with flush; pushes at full and pops at empty are ignored.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        full     = count_q == (AW+1)'(DEPTH);
        empty    = count_q == '0;
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
        count_d  = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head     = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and loads them one at a time into the uart transmitter.
// Define UART_TX_FEEDER_STATUS_EN to add the level and sticky overflow status outputs.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              txclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ld_tx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_enable,
    input  logic              tx_empty,
    output logic              busy
`ifdef UART_TX_FEEDER_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
`endif
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [1:0]              state_q, state_d;
    logic [TW-1:0]           to_q, to_d;
    logic [DATA_W-1:0]       tx_data_q, tx_data_d, head;
    logic                    tx_enable_q, full, empty;
    logic [$clog2(DEPTH):0]  count;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (txclk),
        .rst_n     (reset),
        .flush     (flush),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (state_q == LOAD),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        to_d    = '0;
        case (state_q)
            IDLE:      if (!empty && tx_empty && tx_enable_q) state_d = LOAD;
            LOAD:      state_d = WAIT_ACK;
            WAIT_ACK: begin
                to_d = to_q + 1'b1;
                // An unanswered load is treated as delivered rather than retried.
                if (!tx_empty) state_d = WAIT_DONE;
                else if (to_q == TW'(ACK_TIMEOUT - 1)) state_d = IDLE;
            end
            default:   if (tx_empty) state_d = IDLE;
        endcase
        tx_data_d = (state_q == IDLE && state_d == LOAD) ? head : tx_data_q;
    end

    always_comb begin
        ld_tx_data = state_q == LOAD;
        busy       = (state_q != IDLE) || (count != '0);
        wr_ready   = !full;
        tx_data    = tx_data_q;
        tx_enable  = tx_enable_q;
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            to_q        <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
        end else begin
            to_q        <= to_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= enable;
        end
    end

`ifdef UART_TX_FEEDER_STATUS_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = flush ? 1'b0 : overflow_q || (wr_valid && full);
        overflow   = overflow_q;
        level      = count;
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end
`endif
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Transmit-side feeder that sits directly upstream of the uart transmitter.
- Buffers bytes from a valid/ready producer in a small FIFO.
- Issues one-cycle ld_tx_data loads to the uart only when its tx_empty reports the holding register free, then waits for the character to be accepted and drained before loading the next one.
- Decouples bursty producers from the bit-rate-limited uart.

Parameters:
- DATA_W, 8, byte width; must match the uart tx_data width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ACK_TIMEOUT, 4, cycles to wait in WAIT_ACK for tx_empty to fall before abandoning the handshake.

Ports:
- txclk  in  1  transmit clock; all logic on its rising edge.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- enable  in  1  feeder enable; registered onto tx_enable.
- flush  in  1  synchronous FIFO clear.
- wr_valid  in  1  producer byte valid.
- wr_data  in  DATA_W  producer byte.
- wr_ready  out  1  FIFO not full.
- ld_tx_data  out  1  one-cycle load strobe to the uart.
- tx_data  out  DATA_W  byte presented with ld_tx_data.
- tx_enable  out  1  uart transmitter enable.
- tx_empty  in  1  uart holding register empty.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - rd/wr pointers and count to 0, FSM to IDLE;
  - ld_tx_data=0, tx_data=0, tx_enable=0, busy=0;
  - wr_ready=1 from the first cycle after reset release.
- FIFO:
  - Pointers are $clog2(DEPTH) bits; count is one bit wider.
  - Pointers wrap naturally at DEPTH.
  - wr_ready = (count != DEPTH), derived from registered count.
  - A write is accepted when wr_valid && wr_ready; wr_valid while full is ignored, with no overwrite.
  - A pop in the same cycle as a push at full does not admit the push, because wr_ready was already 0.
- tx_enable is the enable input registered by one cycle.
- FSM states:
  - IDLE: when count!=0 && tx_empty && tx_enable, go to LOAD.
  - LOAD (1 cycle): ld_tx_data=1, tx_data=FIFO head (registered), pop one entry, go to WAIT_ACK.
  - WAIT_ACK: when tx_empty=0, go to WAIT_DONE. If the timeout counter reaches ACK_TIMEOUT with tx_empty still 1, go to IDLE; the byte is considered delivered and is not re-queued.
  - WAIT_DONE: when tx_empty=1, go to IDLE.
- Throughput and latency:
  - Minimum spacing between loads is 4 cycles plus the uart occupancy.
  - Latency from wr_valid into an empty FIFO to ld_tx_data is 2 cycles: write, then IDLE→LOAD decision, with the strobe in cycle 3.
- tx_data holds its last loaded value outside LOAD.
- ld_tx_data is never high for two consecutive cycles.
- enable deasserted mid-transfer: the FSM finishes its current WAIT states but does not leave IDLE while tx_enable=0.
- flush:
  - Clears pointers and count next cycle and has priority over a same-cycle write.
  - Does not abort an in-flight LOAD/WAIT sequence.
  - A flush in the LOAD cycle still delivers that byte.
- busy = (state != IDLE) || (count != 0).
- Mid-operation reset returns everything to reset values immediately; any partially loaded character is the uart's concern.

Optional Feature:
- Macro: UART_TX_FEEDER_STATUS_EN.
- When defined, adds two outputs:
  - level (out, $clog2(DEPTH)+1): current count.
  - overflow (out, 1): sticky flag set on wr_valid && !wr_ready, cleared by flush or reset.
- When undefined, neither port nor its logic exists and the port list is exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state localparams (IDLE=2'd0, LOAD=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3);
  - the default UART_DATA_W=8.
- One natural sub-module: uart_sync_fifo (DATA_W, DEPTH; push/pop/flush, full/empty/count), instantiated once.
- The FSM and timeout counter stay in uart_tx_feeder.

Test Plan:
- Reset release with tx_empty=1, enable=1, no writes -> ld_tx_data stays 0, wr_ready=1, busy=0 for 20 cycles.
- Write 8'hA5; uart model drops tx_empty 1 cycle after the load and raises it 10 cycles later -> one ld_tx_data pulse with tx_data=8'hA5, busy returns to 0 after the tx_empty rise.
- Burst-write 16 bytes 0x00..0x0F with tx_empty held 0 -> wr_ready=0 after the 16th write; a 17th write (0xFF) is dropped; on release, bytes emerge in order 0x00..0x0F.
- tx_empty held 1 with no uart response -> each byte is loaded, ACK timeout after 4 cycles, next byte loaded; no byte repeats.
- Three bytes queued, flush asserted in the LOAD cycle of the first -> first byte is delivered, the remaining two are discarded, count=0.
- Assert reset mid WAIT_DONE -> all outputs return to reset values asynchronously; the FSM restarts from IDLE.
